// File: rtl/ids_pkg.sv
// Shared definitions for the multi-pattern IDS filter: framing codes,
// egress FSM states, oversize margin and a saturating counter helper.
package ids_pkg;

    localparam logic [7:0] CTRL_HDR        = 8'hFF;
    localparam logic [7:0] CTRL_DATA       = 8'h00;
    localparam int         OVERSIZE_MARGIN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } egr_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ids_pattern_cmp.sv
// Combinational compare of one stream word against every pattern slot.
// A slot hits when it is enabled and all mask-selected bits are equal.
module ids_pattern_cmp #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_PATTERNS = 4
) (
    input  logic [DATA_WIDTH-1:0]              data,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pattern,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] mask,
    input  logic [NUM_PATTERNS-1:0]            slot_en,
    output logic [NUM_PATTERNS-1:0]            hit
);

    for (genvar i = 0; i < NUM_PATTERNS; i++) begin : g_slot
        // An all-zero mask on an enabled slot matches any word.
        assign hit[i] = slot_en[i] &&
            (((data ^ pattern[i*DATA_WIDTH +: DATA_WIDTH]) &
              mask[i*DATA_WIDTH +: DATA_WIDTH]) == '0);
    end

endmodule

// File: rtl/ids_multi_filter.sv
// Store-and-forward IDS stage. Each packet is buffered while its payload
// words are compared against NUM_PATTERNS masked patterns; at EOP a
// drop/pass decision is queued and the egress FSM forwards or discards the
// buffered packet. Packets that would overfill the buffer are passed
// cut-through. Optional per-slot packet counters: IDS_PER_SLOT_STATS_EN.
module ids_multi_filter
    import ids_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int NUM_PATTERNS   = 4,
    parameter int BUF_DEPTH_BITS = 9,
    parameter int DEC_DEPTH_BITS = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic [CTRL_WIDTH-1:0]             in_ctrl,
    input  logic                              in_wr,
    output logic                              in_rdy,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    output logic                              out_wr,
    input  logic                              out_rdy,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] cfg_pattern,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] cfg_mask,
    input  logic [NUM_PATTERNS-1:0]           cfg_slot_en,
    input  logic                              cfg_drop_en,
    input  logic                              cmd_clear,
    output logic [31:0]                       match_count,
    output logic [31:0]                       drop_count,
    output logic [31:0]                       oversize_count
`ifdef IDS_PER_SLOT_STATS_EN
    ,
    output logic [NUM_PATTERNS*32-1:0]        slot_hit_count
`endif
);

    localparam int BW       = BUF_DEPTH_BITS + 1;
    localparam int DW       = DEC_DEPTH_BITS + 1;
    localparam int BUF_W    = DATA_WIDTH + CTRL_WIDTH + 1;
    localparam int BUF_DEPTH = 1 << BUF_DEPTH_BITS;
    localparam int DEC_DEPTH = 1 << DEC_DEPTH_BITS;

    localparam logic [BW-1:0] BUF_DEPTH_L = BW'(BUF_DEPTH);
    localparam logic [BW-1:0] FREE_MIN    = BW'(OVERSIZE_MARGIN);
    localparam logic [BW-1:0] OVS_LAST    = BW'(BUF_DEPTH - OVERSIZE_MARGIN - 1);
    localparam logic [BW-1:0] BUF_ONE     = BW'(1);
    localparam logic [DW-1:0] DEC_DEPTH_L = DW'(DEC_DEPTH);
    localparam logic [DW-1:0] DEC_ONE     = DW'(1);

    // ---------------- packet buffer: {eop, ctrl, data} ----------------
    logic [BUF_W-1:0]          buf_mem [BUF_DEPTH];
    logic [BUF_DEPTH_BITS-1:0] buf_wr_ptr, buf_rd_ptr;
    logic [BW-1:0]             buf_cnt;
    logic                      buf_push, buf_pop, buf_empty;
    logic [BUF_W-1:0]          rd_word;
    logic                      rd_eop;
    logic [CTRL_WIDTH-1:0]     rd_ctrl;
    logic [DATA_WIDTH-1:0]     rd_data;

    // ---------------- decision FIFO: 1 = drop ----------------
    logic [DEC_DEPTH-1:0]      dec_mem;
    logic [DEC_DEPTH_BITS-1:0] dec_wr_ptr, dec_rd_ptr;
    logic [DW-1:0]             dec_cnt;
    logic                      dec_push, dec_pop, dec_full, dec_din, dec_head;

    // ---------------- ingress state ----------------
    logic                    rdy_en;
    logic                    seen_payload;
    logic                    oversize;
    logic [BW-1:0]           pkt_words;
    logic [NUM_PATTERNS-1:0] slot_sticky;
    logic [NUM_PATTERNS-1:0] cmp_hit, word_hit;
    logic                    pkt_hit;
    logic                    in_payload, in_eop, eop_accept, at_limit;
    logic                    eop_push, ovs_push;

    // ---------------- egress state ----------------
    egr_state_t state;
    logic       drop_done;

    ids_pattern_cmp #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_PATTERNS(NUM_PATTERNS)
    ) u_cmp (
        .data   (in_data),
        .pattern(cfg_pattern),
        .mask   (cfg_mask),
        .slot_en(cfg_slot_en),
        .hit    (cmp_hit)
    );

    // Framing and decision generation for the word being written.
    assign in_payload = (in_ctrl == CTRL_WIDTH'(CTRL_DATA));
    assign in_eop     = (in_ctrl != '0) && seen_payload;
    assign buf_push   = in_wr && (buf_cnt != BUF_DEPTH_L);
    assign eop_accept = buf_push && in_eop;
    assign word_hit   = cmp_hit & {NUM_PATTERNS{in_payload && !oversize}};
    assign pkt_hit    = |slot_sticky;
    assign at_limit   = !oversize && !in_eop && (pkt_words == OVS_LAST);
    assign eop_push   = eop_accept && !oversize;
    assign ovs_push   = buf_push && at_limit;
    assign dec_push   = (eop_push || ovs_push) && !dec_full;
    assign dec_din    = eop_push && pkt_hit && cfg_drop_en;

    assign dec_full  = (dec_cnt == DEC_DEPTH_L);
    assign dec_head  = dec_mem[dec_rd_ptr];
    assign buf_empty = (buf_cnt == '0);
    assign in_rdy    = rdy_en && ((BUF_DEPTH_L - buf_cnt) > FREE_MIN) && !dec_full;

    assign rd_word = buf_mem[buf_rd_ptr];
    assign rd_eop  = rd_word[BUF_W-1];
    assign rd_ctrl = rd_word[DATA_WIDTH +: CTRL_WIDTH];
    assign rd_data = rd_word[DATA_WIDTH-1:0];

    // Egress pops: FWD waits for downstream, DROP drains unconditionally.
    assign buf_pop   = !buf_empty &&
                       ((state == FWD && out_rdy) || (state == DROP));
    assign dec_pop   = (state == IDLE) && (dec_cnt != '0);
    assign drop_done = (state == DROP) && buf_pop && rd_eop;

    // in_rdy held low for the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (reset) rdy_en <= 1'b0;
        else       rdy_en <= 1'b1;
    end

    // Buffer storage write; EOP tag stored so egress needs no reframing.
    always_ff @(posedge clk) begin
        if (buf_push) buf_mem[buf_wr_ptr] <= {in_eop, in_ctrl, in_data};
    end

    // Buffer pointers and occupancy; push+pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_wr_ptr <= '0;
            buf_rd_ptr <= '0;
            buf_cnt    <= '0;
        end else begin
            if (buf_push) buf_wr_ptr <= buf_wr_ptr + 1'b1;
            if (buf_pop)  buf_rd_ptr <= buf_rd_ptr + 1'b1;
            case ({buf_push, buf_pop})
                2'b10:   buf_cnt <= buf_cnt + BUF_ONE;
                2'b01:   buf_cnt <= buf_cnt - BUF_ONE;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Decision FIFO storage.
    always_ff @(posedge clk) begin
        if (dec_push) dec_mem[dec_wr_ptr] <= dec_din;
    end

    // Decision FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_wr_ptr <= '0;
            dec_rd_ptr <= '0;
            dec_cnt    <= '0;
        end else begin
            if (dec_push) dec_wr_ptr <= dec_wr_ptr + 1'b1;
            if (dec_pop)  dec_rd_ptr <= dec_rd_ptr + 1'b1;
            case ({dec_push, dec_pop})
                2'b10:   dec_cnt <= dec_cnt + DEC_ONE;
                2'b01:   dec_cnt <= dec_cnt - DEC_ONE;
                default: dec_cnt <= dec_cnt;
            endcase
        end
    end

    // Per-packet ingress tracking: framing, word count, sticky slot hits.
    // Once oversize, counting and matching stop until the packet's EOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_payload <= 1'b0;
            oversize     <= 1'b0;
            pkt_words    <= '0;
            slot_sticky  <= '0;
        end else if (buf_push) begin
            if (in_eop) begin
                seen_payload <= 1'b0;
                oversize     <= 1'b0;
                pkt_words    <= '0;
                slot_sticky  <= '0;
            end else begin
                if (in_payload) seen_payload <= 1'b1;
                if (!oversize)  pkt_words    <= pkt_words + BUF_ONE;
                if (at_limit)   oversize     <= 1'b1;
                slot_sticky <= slot_sticky | word_hit;
            end
        end
    end

    // Egress FSM with registered stream outputs (1-cycle read latency).
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (dec_pop) state <= dec_head ? DROP : FWD;
                end
                FWD: begin
                    if (buf_pop) begin
                        out_wr   <= 1'b1;
                        out_data <= rd_data;
                        out_ctrl <= rd_ctrl;
                        if (rd_eop) state <= IDLE;
                    end
                end
                DROP: begin
                    if (drop_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Aggregate statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || cmd_clear) begin
            match_count    <= '0;
            drop_count     <= '0;
            oversize_count <= '0;
        end else begin
            if (eop_accept && pkt_hit) match_count    <= sat_inc(match_count);
            if (drop_done)             drop_count     <= sat_inc(drop_count);
            if (ovs_push)              oversize_count <= sat_inc(oversize_count);
        end
    end

`ifdef IDS_PER_SLOT_STATS_EN
    // Per-slot packet counters: each slot counts once per packet it hit.
    always_ff @(posedge clk) begin
        if (reset || cmd_clear) begin
            slot_hit_count <= '0;
        end else if (eop_accept) begin
            for (int i = 0; i < NUM_PATTERNS; i++) begin
                if (slot_sticky[i])
                    slot_hit_count[i*32 +: 32] <= sat_inc(slot_hit_count[i*32 +: 32]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ids_multi_filter.sv
// Directed bench for ids_multi_filter: a table of single-packet vectors
// followed by hand-written sequences for back-to-back drop/forward with a
// toggling out_rdy, an oversize packet, counter saturation and clear.
module tb_ids_multi_filter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NP = 4;

    typedef logic [CW+DW-1:0] word_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DW-1:0]     in_data = '0;
    logic [CW-1:0]     in_ctrl = '0;
    logic              in_wr = 1'b0;
    logic              in_rdy;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy = 1'b1;
    logic [NP*DW-1:0]  cfg_pattern = '0;
    logic [NP*DW-1:0]  cfg_mask = '0;
    logic [NP-1:0]     cfg_slot_en = '0;
    logic              cfg_drop_en = 1'b0;
    logic              cmd_clear = 1'b0;
    logic [31:0]       match_count, drop_count, oversize_count;
`ifdef IDS_PER_SLOT_STATS_EN
    logic [NP*32-1:0]  slot_hit_count;
`endif

    always #5 clk = ~clk;

    ids_multi_filter dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .in_wr         (in_wr),
        .in_rdy        (in_rdy),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .out_wr        (out_wr),
        .out_rdy       (out_rdy),
        .cfg_pattern   (cfg_pattern),
        .cfg_mask      (cfg_mask),
        .cfg_slot_en   (cfg_slot_en),
        .cfg_drop_en   (cfg_drop_en),
        .cmd_clear     (cmd_clear),
        .match_count   (match_count),
        .drop_count    (drop_count),
        .oversize_count(oversize_count)
`ifdef IDS_PER_SLOT_STATS_EN
        ,
        .slot_hit_count(slot_hit_count)
`endif
    );

    int    n_vec = 0;
    int    n_err = 0;
    word_t tx_q[$];
    word_t exp_q[$];
    word_t out_q[$];
    logic  toggle_rdy = 1'b0;

    // Output collector, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset && out_wr) out_q.push_back({out_ctrl, out_data});
    end

    // Downstream ready: steady high, or toggling every cycle.
    always @(negedge clk) begin
        out_rdy = toggle_rdy ? ~out_rdy : 1'b1;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name);
        int bad;
        bad = -1;
        n_vec++;
        if (out_q.size() != exp_q.size()) bad = 0;
        else foreach (exp_q[k]) if (bad < 0 && out_q[k] !== exp_q[k]) bad = k;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: got %0d words (first diff at %0d) required %0d words",
                     name, out_q.size(), bad, exp_q.size());
        end
        out_q.delete();
    endtask

    // Append one packet: header, n_pay payload words, EOP. hit puts the
    // slot-2 matching word in the first payload position.
    task automatic build_pkt(input int id, input int n_pay, input bit hit);
        logic [15:0] id16;
        id16 = 16'(id);
        tx_q.push_back({8'hFF, 64'hCAFE_0000_0000_0000 | 64'(id16)});
        for (int i = 0; i < n_pay; i++) begin
            if (hit && i == 0) tx_q.push_back({8'h00, 64'h1234_DEAD_BEEF_5678});
            else               tx_q.push_back({8'h00, 16'h0, id16, 16'h0, 16'(i)});
        end
        tx_q.push_back({8'h04, 64'hE0E0_0000_0000_0000 | 64'(id16)});
    endtask

    // Write tx_q into the DUT honouring in_rdy; optional clear on the EOP cycle.
    task automatic send_pkt(input bit clr_eop);
        foreach (tx_q[k]) begin
            int t;
            t = 0;
            @(negedge clk);
            in_wr = 1'b0;
            cmd_clear = 1'b0;
            while (!in_rdy && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL in_rdy_wait: got in_rdy=0 for %0d cycles required 1", t);
                return;
            end
            in_wr = 1'b1;
            {in_ctrl, in_data} = tx_q[k];
            cmd_clear = clr_eop && (k == tx_q.size() - 1);
        end
        @(negedge clk);
        in_wr = 1'b0;
        cmd_clear = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (out_q.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic set_cfg(input bit drop_en, input logic [NP-1:0] slot_en, input bit zmask);
        cfg_pattern = {64'h3333_3333_3333_3333, 64'h0000_DEAD_BEEF_0000,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        cfg_mask    = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_FFFF_FFFF_0000,
                       64'hFFFF_FFFF_FFFF_FFFF,
                       zmask ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF};
        cfg_slot_en = slot_en;
        cfg_drop_en = drop_en;
    endtask

    typedef struct {
        int          n_pay;
        bit          hit;
        bit          drop_en;
        logic [3:0]  slot_en;
        bit          zmask;
        bit          exp_fwd;
        logic [31:0] exp_match;
        logic [31:0] exp_drop;
    } vec_t;

    vec_t vt[7];

    initial begin
        int s;
        // n_pay, hit, drop_en, slot_en, zmask, fwd, match, drop (cumulative)
        vt[0] = '{4, 1'b0, 1'b1, 4'hF,    1'b0, 1'b1, 32'd0, 32'd0};
        vt[1] = '{4, 1'b1, 1'b1, 4'hF,    1'b0, 1'b0, 32'd1, 32'd1};
        vt[2] = '{4, 1'b1, 1'b0, 4'hF,    1'b0, 1'b1, 32'd2, 32'd1};
        vt[3] = '{1, 1'b1, 1'b1, 4'hF,    1'b0, 1'b0, 32'd3, 32'd2};
        vt[4] = '{6, 1'b0, 1'b1, 4'hF,    1'b0, 1'b1, 32'd3, 32'd2};
        vt[5] = '{4, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 32'd3, 32'd2};
        vt[6] = '{2, 1'b0, 1'b1, 4'hF,    1'b1, 1'b0, 32'd4, 32'd3};

        set_cfg(1'b1, 4'hF, 1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        check32("rst_out_wr",   32'(out_wr), 32'd0);
        check32("rst_out_data", out_data[31:0] | out_data[63:32], 32'd0);
        check32("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        check32("rst_in_rdy",   32'(in_rdy), 32'd0);
        check32("rst_match",    match_count, 32'd0);
        check32("rst_drop",     drop_count, 32'd0);
        check32("rst_oversize", oversize_count, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check32("post_rst_in_rdy", 32'(in_rdy), 32'd1);

        // Table of single packets.
        for (int i = 0; i < 7; i++) begin
            set_cfg(vt[i].drop_en, vt[i].slot_en, vt[i].zmask);
            tx_q.delete();
            build_pkt(i + 1, vt[i].n_pay, vt[i].hit);
            exp_q.delete();
            if (vt[i].exp_fwd) exp_q = tx_q;
            send_pkt(1'b0);
            @(negedge clk);
            check32($sformatf("v%0d_latency", i), 32'(out_q.size()), 32'd0);
            wait_out(exp_q.size());
            check_q($sformatf("v%0d_stream", i));
            check32($sformatf("v%0d_match", i), match_count, vt[i].exp_match);
            check32($sformatf("v%0d_drop", i), drop_count, vt[i].exp_drop);
        end

        // Dropped packet back-to-back with a clean one, out_rdy toggling.
        set_cfg(1'b1, 4'hF, 1'b0);
        toggle_rdy = 1'b1;
        tx_q.delete();
        build_pkt(20, 3, 1'b1);
        s = tx_q.size();
        build_pkt(21, 5, 1'b0);
        exp_q.delete();
        for (int k = s; k < tx_q.size(); k++) exp_q.push_back(tx_q[k]);
        send_pkt(1'b0);
        wait_out(exp_q.size());
        toggle_rdy = 1'b0;
        check_q("b2b_stream");
        check32("b2b_match", match_count, 32'd5);
        check32("b2b_drop",  drop_count, 32'd4);

        // 600-word packet: forced pass, cut-through, no deadlock.
        tx_q.delete();
        build_pkt(30, 598, 1'b0);
        exp_q = tx_q;
        send_pkt(1'b0);
        wait_out(exp_q.size());
        check_q("ovs_stream");
        check32("ovs_count", oversize_count, 32'd1);
        check32("ovs_match", match_count, 32'd5);

        // Saturation: counter parked at all-ones, then a matching packet.
        set_cfg(1'b0, 4'hF, 1'b0);
        @(negedge clk);
        force dut.match_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.match_count;
        tx_q.delete();
        build_pkt(40, 2, 1'b1);
        exp_q = tx_q;
        send_pkt(1'b0);
        wait_out(exp_q.size());
        check_q("sat_stream");
        check32("sat_match", match_count, 32'hFFFF_FFFF);

        // Clear on the same cycle as an EOP increment.
        tx_q.delete();
        build_pkt(41, 2, 1'b1);
        exp_q = tx_q;
        send_pkt(1'b1);
        wait_out(exp_q.size());
        check_q("clr_stream");
        check32("clr_match",    match_count, 32'd0);
        check32("clr_drop",     drop_count, 32'd0);
        check32("clr_oversize", oversize_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
